mult_div_unit: RTL and testbench

- Iterative MULT/MULTU/DIV/DIVU unit in the EX stage.
- Owns the HI/LO registers and produces `stall_req`. `stall_req` drives low the enable of the upstream IF/ID and ID/EX pipeline registers while an operation is in flight.
- HI/LO are consumed by MFHI/MFLO through the EX/MEM pipeline register.

---
 rtl/mips_md_pkg.sv | 26 ++
 rtl/md_sign_fix.sv | 23 ++
 rtl/mult_div_unit.sv | 194 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes, FSM states and the
// divide-by-zero LO value.
package mips_md_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_SIGN = 2'b11
   } md_state_e;

   // Wide enough for any supported DATA_WIDTH; the unit slices off what it needs.
   localparam logic [63:0] DIV0_LO = '1;

   function automatic logic op_is_signed(input md_op_e o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation of a 2N-bit product and two N-bit values.
// The N-bit paths carry quotient/remainder in SIGN and rs/rt magnitudes in IDLE.
module md_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] prod_in,
   input  logic               prod_neg,
   output logic [2*WIDTH-1:0] prod_out,
   input  logic [WIDTH-1:0]   quot_in,
   input  logic               quot_neg,
   output logic [WIDTH-1:0]   quot_out,
   input  logic [WIDTH-1:0]   rem_in,
   input  logic               rem_neg,
   output logic [WIDTH-1:0]   rem_out
);

   always_comb begin
      prod_out = prod_neg ? -prod_in : prod_in;
      quot_out = quot_neg ? -quot_in : quot_in;
      rem_out  = rem_neg  ? -rem_in  : rem_in;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Define MULT_FAST_EN for a single-cycle
// array multiplier; division stays iterative in both builds.
module mult_div_unit
   import mips_md_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] rs_data,
   input  logic [DATA_WIDTH-1:0] rt_data,
   input  logic                  mf_req,
   input  logic                  mthi,
   input  logic                  mtlo,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  stall_req,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int unsigned N = DATA_WIDTH;

   md_state_e            state_q, state_d;
   md_op_e               op_q, op_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]       acc_q, acc_d;
   logic [N-1:0]         mcand_q, mcand_d;
   logic                 rs_sign_q, rs_sign_d;
   logic                 rt_sign_q, rt_sign_d;
   logic [N-1:0]         hi_q, hi_d;
   logic [N-1:0]         lo_q, lo_d;
   logic                 done_q, done_d;

   logic                 in_signed, op_signed;
   logic [2*N-1:0]       sf_prod_out;
   logic                 sf_prod_neg, sf_quot_neg, sf_rem_neg;
   logic [N-1:0]         sf_quot_in, sf_quot_out, sf_rem_in, sf_rem_out;
   logic [N:0]           div_trial;
   logic                 last_iter;

   assign in_signed = op_is_signed(md_op_e'(op));
   assign op_signed = op_is_signed(op_q);
   assign last_iter = (cnt_q == CNT_WIDTH'(N - 1));

   // IDLE: quot path yields |rs|, rem path yields |rt|. Otherwise they fix up the result.
   always_comb begin
      sf_prod_neg = op_signed & (rs_sign_q ^ rt_sign_q);
      if (state_q == S_IDLE) begin
         sf_quot_in  = rs_data;
         sf_quot_neg = in_signed & rs_data[N-1];
         sf_rem_in   = rt_data;
         sf_rem_neg  = in_signed & rt_data[N-1];
      end else begin
         sf_quot_in  = acc_q[N-1:0];
         sf_quot_neg = op_signed & (rs_sign_q ^ rt_sign_q);
         sf_rem_in   = acc_q[2*N-1:N];
         sf_rem_neg  = op_signed & rs_sign_q;
      end
   end

   md_sign_fix #(
      .WIDTH(N)
   ) u_sign_fix (
      .prod_in (acc_q),
      .prod_neg(sf_prod_neg),
      .prod_out(sf_prod_out),
      .quot_in (sf_quot_in),
      .quot_neg(sf_quot_neg),
      .quot_out(sf_quot_out),
      .rem_in  (sf_rem_in),
      .rem_neg (sf_rem_neg),
      .rem_out (sf_rem_out)
   );

   // Restoring step: partial remainder with the next dividend bit shifted in, minus divisor.
   assign div_trial = acc_q[2*N-1:N-1] - {1'b0, mcand_q};

`ifndef MULT_FAST_EN
   logic [N:0] mul_sum;
   assign mul_sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? mcand_q : {N{1'b0}})};
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      rs_sign_d = rs_sign_q;
      rt_sign_d = rt_sign_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d      = md_op_e'(op);
               rs_sign_d = rs_data[N-1];
               rt_sign_d = rt_data[N-1];
               cnt_d     = '0;
               if (op[1]) begin
                  acc_d   = {{N{1'b0}}, sf_quot_out};
                  mcand_d = sf_rem_out;
                  state_d = S_DIV;
               end else begin
                  acc_d   = {{N{1'b0}}, sf_rem_out};
                  mcand_d = sf_quot_out;
                  state_d = S_MUL;
               end
            end else begin
               if (mthi) hi_d = wr_data;
               if (mtlo) lo_d = wr_data;
            end
         end
         S_MUL: begin
`ifdef MULT_FAST_EN
            acc_d   = {{N{1'b0}}, mcand_q} * {{N{1'b0}}, acc_q[N-1:0]};
            state_d = S_SIGN;
`else
            acc_d = {mul_sum, acc_q[N-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) state_d = S_SIGN;
`endif
         end
         S_DIV: begin
            if (!div_trial[N]) acc_d = {div_trial[N-1:0], acc_q[N-2:0], 1'b1};
            else               acc_d = {acc_q[2*N-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (last_iter) state_d = S_SIGN;
         end
         S_SIGN: begin
            if (op_q[1]) begin
               // Zero divisor leaves the dividend as remainder, so HI already equals rs_data.
               lo_d = (mcand_q == '0) ? DIV0_LO[N-1:0] : sf_quot_out;
               hi_d = sf_rem_out;
            end else begin
               {hi_d, lo_d} = sf_prod_out;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end else if (flush) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         op_q      <= MD_MULT;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         rs_sign_q <= 1'b0;
         rt_sign_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         rs_sign_q <= rs_sign_d;
         rt_sign_q <= rt_sign_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign stall_req = busy & (start | mf_req | mthi | mtlo);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expected latencies follow MULT_FAST_EN.
module tb_mult_div_unit;
   import mips_md_pkg::*;

`ifdef MULT_FAST_EN
   localparam int MUL_LAT  = 3;
   localparam int MUL_BUSY = 2;
`else
   localparam int MUL_LAT  = 34;
   localparam int MUL_BUSY = 33;
`endif
   localparam int DIV_LAT  = 34;
   localparam int DIV_BUSY = 33;

   logic        clk = 1'b0;
   logic        reset, start, mf_req, mthi, mtlo, flush;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data, wr_data;
   logic        busy, done, stall_req;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   mult_div_unit #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .mf_req   (mf_req),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .wr_data  (wr_data),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .stall_req(stall_req),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   // Launch one op at a negedge; k=1 is the cycle after the edge that samples start.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int dc, output int bc, output logic [31:0] h,
                         output logic [31:0] l);
      dc = -1; bc = 0; h = 'x; l = 'x;
      @(negedge clk);
      op = o; rs_data = a; rt_data = b; start = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) bc++;
         if (done && dc < 0) begin dc = k; h = hi; l = lo; end
         if (dc >= 0 && !busy && !done) break;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 0; mf_req = 0; mthi = 0; mtlo = 0; flush = 0;
      op = 2'b00; rs_data = 0; rt_data = 0; wr_data = 0;
      repeat (2) @(negedge clk);
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
      total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++;
      if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_multu_max;
      int dc, bc; logic [31:0] h, l;
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc, h, l);
      total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", h); end
      total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", l); end
      total++; if (dc !== MUL_LAT) begin bad++; $display("FAIL multu_latency got=%0d exp=%0d", dc, MUL_LAT); end
      total++; if (bc !== MUL_BUSY) begin bad++; $display("FAIL multu_busy got=%0d exp=%0d", bc, MUL_BUSY); end
   endtask

   task automatic test_ops;
      logic [1:0]  t_op [10];
      logic [31:0] t_a [10], t_b [10], t_h [10], t_l [10];
      int dc, bc, lat; logic [31:0] h, l;
      t_op[0] = MD_MULT;  t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd7;  t_h[0] = 32'hFFFF_FFFF; t_l[0] = 32'hFFFF_FFEB;
      t_op[1] = MD_MULT;  t_a[1] = 32'hFFFF_FFFE; t_b[1] = 32'hFFFF_FFFD; t_h[1] = 32'h0; t_l[1] = 32'd6;
      t_op[2] = MD_MULTU; t_a[2] = 32'h0001_0000; t_b[2] = 32'h0001_0000; t_h[2] = 32'd1; t_l[2] = 32'h0;
      t_op[3] = MD_DIV;   t_a[3] = 32'hFFFF_FFF9; t_b[3] = 32'd2;  t_h[3] = 32'hFFFF_FFFF; t_l[3] = 32'hFFFF_FFFD;
      t_op[4] = MD_DIVU;  t_a[4] = 32'd100;       t_b[4] = 32'd7;  t_h[4] = 32'd2;         t_l[4] = 32'd14;
      t_op[5] = MD_DIV;   t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF; t_h[5] = 32'h0; t_l[5] = 32'h8000_0000;
      t_op[6] = MD_DIV;   t_a[6] = 32'd7;         t_b[6] = 32'hFFFF_FFFE; t_h[6] = 32'd1; t_l[6] = 32'hFFFF_FFFD;
      t_op[7] = MD_DIVU;  t_a[7] = 32'h0000_1234; t_b[7] = 32'd0;  t_h[7] = 32'h0000_1234; t_l[7] = 32'hFFFF_FFFF;
      t_op[8] = MD_DIV;   t_a[8] = 32'hFFFF_FFFB; t_b[8] = 32'd0;  t_h[8] = 32'hFFFF_FFFB; t_l[8] = 32'hFFFF_FFFF;
      t_op[9] = MD_DIVU;  t_a[9] = 32'hFFFF_FFFF; t_b[9] = 32'd1;  t_h[9] = 32'h0;         t_l[9] = 32'hFFFF_FFFF;
      for (int i = 0; i < 10; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], dc, bc, h, l);
         lat = t_op[i][1] ? DIV_LAT : MUL_LAT;
         total++;
         if (h !== t_h[i]) begin bad++; $display("FAIL op%0d_hi got=%h exp=%h", i, h, t_h[i]); end
         total++;
         if (l !== t_l[i]) begin bad++; $display("FAIL op%0d_lo got=%h exp=%h", i, l, t_l[i]); end
         total++;
         if (dc !== lat) begin bad++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, dc, lat); end
      end
   endtask

   task automatic test_flush;
      int done_seen = 0;
      @(negedge clk);
      mthi = 1'b1; wr_data = 32'hAAAA_5555;
      @(negedge clk);
      mthi = 1'b0;
      total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL mthi_idle got=%h exp=aaaa5555", hi); end
`ifdef MULT_FAST_EN
      op = MD_DIV;
`else
      op = MD_MULT;
`endif
      rs_data = 32'd1234; rt_data = 32'hFFFF_FFF0; start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) done_seen++;
         if (k == 10) flush = 1'b1;
         if (k == 11) begin
            flush = 1'b0;
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
         end
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", done_seen); end
      total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL flush_hi got=%h exp=aaaa5555", hi); end
   endtask

   task automatic test_stall;
      int busy_cyc = 0, stall_miss = 0, dc = -1;
      logic [31:0] h = 'x, l = 'x;
      logic st_done = 1'bx;
      @(negedge clk);
      op = MD_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1; mf_req = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            busy_cyc++;
            if (stall_req !== 1'b1) stall_miss++;
         end
         if (done && dc < 0) begin dc = k; h = hi; l = lo; st_done = stall_req; end
         mthi = (k == 5);
         wr_data = 32'h1111_1111;
         if (dc >= 0) break;
      end
      mf_req = 1'b0; mthi = 1'b0;
      total++; if (busy_cyc !== DIV_BUSY) begin bad++; $display("FAIL stall_busy got=%0d exp=%0d", busy_cyc, DIV_BUSY); end
      total++; if (stall_miss !== 0) begin bad++; $display("FAIL stall_busy_cycles got=%0d exp=0", stall_miss); end
      total++; if (st_done !== 1'b0) begin bad++; $display("FAIL stall_done_cycle got=%b exp=0", st_done); end
      total++; if (h !== 32'd2) begin bad++; $display("FAIL mthi_busy_hi got=%h exp=00000002", h); end
      total++; if (l !== 32'd14) begin bad++; $display("FAIL mthi_busy_lo got=%h exp=0000000e", l); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0000_0055;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      op = MD_DIV; rs_data = 32'h0000_7FFF; rt_data = 32'd3; start = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_busy got=%b exp=1", busy); end
      #2 reset = 1'b0;
      #1;
      total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi got=%h exp=0", hi); end
      total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo got=%h exp=0", lo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_ops();
      test_flush();
      test_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
